booth_mult_unit: RTL and testbench
==================================

BOOTH_MULT_UNIT -- requirements
Module: booth_mult_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter STEPS, default WIDTH+1, number of Booth iterations.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  multiply request from the ID/EX stage (ALUOp decodes mult/multu).
REQ-006 is_unsigned  input  1  1 = multu (zero-extend operands); 0 = mult (sign-extend operands).
REQ-007 multiplicand  input  WIDTH  ReadData1 from the ID/EX register.
REQ-008 multiplier  input  WIDTH  ReadData2 from the ID/EX register.
REQ-009 flush  input  1  branch-taken squash (PCSource); aborts the operation in progress.
REQ-010 busy  output  1  high while in CALC.
REQ-011 stall  output  1  freezes PC, IF/ID and ID/EX.
REQ-012 done  output  1  one-cycle pulse when hi/lo update.
REQ-013 hi  output  WIDTH  upper product word, registered.
REQ-014 lo  output  WIDTH  lower product word, registered.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 Transitions SHALL be:
- IDLE -> CALC when start=1 and flush=0.
- CALC -> DONE after STEPS iterations.
- CALC -> IDLE on flush=1.
- DONE -> IDLE unconditionally.
REQ-017 On IDLE->CALC the unit SHALL load:
- M = the multiplicand extended to WIDTH+1 bits per is_unsigned.
- Q = the multiplier extended the same way.
- Accumulator A (WIDTH+2 bits) = 0.
- q_m1 = 0.
- Step counter = 0.
REQ-018 Each CALC cycle SHALL examine {Q[0],q_m1}:
- 01: A = A+M.
- 10: A = A−M.
- 00 or 11: A unchanged.
- Then arithmetic-shift {A,Q,q_m1} right by one.
- Then increment the counter.
REQ-019 After step STEPS the unit SHALL write {hi,lo} = the low 2*WIDTH bits of {A,Q} and move to DONE.
REQ-020 done SHALL be 1 only in DONE.
REQ-021 Latency SHALL be STEPS+1 cycles from the cycle in which start is sampled to the done cycle (34 for WIDTH=32).
REQ-022 stall SHALL be combinational and equal (state==IDLE && start && !flush) || state==CALC.
REQ-023 stall SHALL be 0 in DONE, so that the pipeline advances exactly once.
REQ-024 start SHALL be ignored in CALC and DONE; no queuing, and the operands already latched are unaffected.
REQ-025 flush in CALC SHALL abort the operation:
- Next state IDLE.
- hi/lo unchanged.
- done never asserted for that operation.
REQ-026 flush in DONE SHALL have no effect; hi/lo are already committed.
REQ-027 hi/lo SHALL hold their value until the next DONE.
REQ-028 Input operands SHALL be sampled only on IDLE->CALC.
REQ-029 All arithmetic SHALL be performed at WIDTH+2 bits; no overflow indication exists because the product always fits.

Reset
REQ-030 rst=1 SHALL immediately force:
- state = IDLE.
- counter, A, Q, M, q_m1 = 0.
- hi = lo = 0.
- busy = done = 0.
REQ-031 stall SHALL be 0 during reset irrespective of start.
REQ-032 rst asserted mid-CALC SHALL abort with the same result as REQ-030; no partial product is written.
REQ-033 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-034 Package mips_mult_pkg SHALL hold:
- The state enum (IDLE/CALC/DONE).
- MULT_WIDTH=32.
- MULT_STEPS=33.
- The counter width constant (6).
REQ-035 One combinational sub-module, booth_step, SHALL implement a single Booth iteration.
- Inputs: A, Q, q_m1, M.
- Outputs: the next A, Q, q_m1.
REQ-036 The top level SHALL contain the FSM, the counter, the operand registers and the hi/lo registers.
REQ-037 The top level SHALL be integrated in the execute stage; stall gates the PC and IF/ID/ID/EX write enables.

Verification
REQ-038 Signed basic: start, multiplicand=7, multiplier=6, is_unsigned=0 -> done at cycle 34, hi=0x00000000, lo=0x0000002A.
REQ-039 Signed negative: −1 × 1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-040 Unsigned: 0xFFFFFFFF × 0xFFFFFFFF with is_unsigned=1 -> hi=0xFFFFFFFE, lo=0x00000001; the same operands signed -> hi=0, lo=1.
REQ-041 Flush: flush=1 at CALC step 10 after a prior result 42 ->
- busy=0 next cycle.
- done never pulses.
- hi/lo remain 0/42.
- stall=0.
REQ-042 Start while busy: toggle operands and pulse start during CALC -> the result matches the original operands and exactly one done pulse occurs.
REQ-043 Reset mid-op: assert rst at step 20 -> all outputs 0 immediately; a new 3×5 started afterwards yields lo=15 after 34 cycles.

Source files
------------

// File: rtl/mips_mult_pkg.sv
// Shared constants and FSM state type for the execute-stage Booth multiplier.
package mips_mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = MULT_WIDTH + 1;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// right shift of {A,Q,q_m1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH+1:0] a,
  input  logic        [WIDTH:0]   q,
  input  logic                    q_m1,
  input  logic signed [WIDTH:0]   m,
  output logic signed [WIDTH+1:0] next_a,
  output logic        [WIDTH:0]   next_q,
  output logic                    next_q_m1
);

  logic signed [WIDTH+1:0] m_wide;
  logic signed [WIDTH+1:0] sum;

  // A carries one guard bit over M so that A-M for the most negative M cannot wrap.
  assign m_wide = {m[WIDTH], m};

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m_wide;
      2'b10:   sum = a - m_wide;
      default: sum = a;
    endcase
    next_a    = {sum[WIDTH+1], sum[WIDTH+1:1]};
    next_q    = {sum[0], q[WIDTH:1]};
    next_q_m1 = q[0];
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Multi-cycle Booth multiplier for mult/multu in the execute stage; stalls the
// front of the pipeline while iterating and commits hi/lo on completion.
module booth_mult_unit
  import mips_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int STEPS = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (STEPS < (2 ** MULT_CNT_W)) ? MULT_CNT_W : $clog2(STEPS + 1);

  mult_state_e state, next_state;

  logic signed [WIDTH+1:0] acc;
  logic        [WIDTH:0]   q_reg;
  logic                    q_m1;
  logic signed [WIDTH:0]   m_reg;
  logic        [CNT_W-1:0] count;

  logic signed [WIDTH+1:0] step_a;
  logic        [WIDTH:0]   step_q;
  logic                    step_q_m1;
  logic        [2*WIDTH-1:0] product;
  logic                    accept;
  logic                    last_step;

  function automatic logic signed [WIDTH:0] extend_operand(input logic [WIDTH-1:0] v,
                                                           input logic uns);
    return {(uns ? 1'b0 : v[WIDTH-1]), v};
  endfunction

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (acc),
    .q         (q_reg),
    .q_m1      (q_m1),
    .m         (m_reg),
    .next_a    (step_a),
    .next_q    (step_q),
    .next_q_m1 (step_q_m1)
  );

  assign accept    = (state == IDLE) && start && !flush;
  assign last_step = (count == CNT_W'(STEPS - 1));
  // Only the low 2*WIDTH bits of {A,Q} are the product; the rest is sign extension.
  assign product   = {step_a[WIDTH-2:0], step_q};

  assign busy  = (state == CALC);
  assign done  = (state == DONE);
  assign stall = !rst && (accept || (state == CALC));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC: begin
        if (flush)          next_state = IDLE;
        else if (last_step) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // operand load, iteration and result commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      m_reg <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_reg <= extend_operand(multiplicand, is_unsigned);
            q_reg <= extend_operand(multiplier, is_unsigned);
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        CALC: begin
          if (!flush) begin
            acc   <= step_a;
            q_reg <= step_q;
            q_m1  <= step_q_m1;
            count <= count + CNT_W'(1);
            if (last_step) begin
              hi <= product[2*WIDTH-1:WIDTH];
              lo <= product[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Randomized and directed bench for booth_mult_unit against a plain-arithmetic product model.
module tb_booth_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_unsigned;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;

  booth_mult_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_unsigned  (is_unsigned),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .flush        (flush),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_count++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns);
    logic [63:0] ea, eb;
    ea = uns ? {32'b0, a} : {{32{a[31]}}, a};
    eb = uns ? {32'b0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after start was sampled.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic uns);
    multiplicand = a;
    multiplier   = b;
    is_unsigned  = uns;
    start        = 1'b1;
    #1 check("stall_on_start", stall, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_calc", busy, 1);
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic uns);
    logic [63:0] exp;
    int cyc;
    int pulses;
    exp = model(a, b, uns);
    pulses = done_count;
    launch(a, b, uns);
    cyc = 1;
    wait_done(cyc);
    check({tag, "_latency"}, cyc, 34);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    check({tag, "_stall_done"}, stall, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_one_pulse"}, done_count - pulses, 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        ru;
    logic [63:0] exp;
    int cyc;
    int pulses;

    rst = 1'b1; start = 1'b1; flush = 1'b0; is_unsigned = 1'b0;
    multiplicand = 32'd9; multiplier = 32'd9;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    run_op("signed_7x6", 32'd7, 32'd6, 1'b0);
    run_op("neg1x1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("smax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("umin", 32'h8000_0000, 32'h8000_0000, 1'b1);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      ru = 1'($urandom_range(0, 1));
      if (i == 3) rb = 32'h7FFF_FFFF;
      if (i == 4) ra = 32'h0;
      run_op($sformatf("rand%0d", i), ra, rb, ru);
    end

    // flush during iteration after a known 42 result
    run_op("prior42", 32'd7, 32'd6, 1'b0);
    pulses = done_count;
    launch(32'd123, 32'd456, 1'b0);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_stall", stall, 0);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_no_done", done_count - pulses, 0);
    check("flush_hi", hi, 0);
    check("flush_lo", lo, 42);

    // start pulsed with new operands while iterating must be ignored
    exp = model(32'hFFFF_FFF3, 32'd1000, 1'b0);
    pulses = done_count;
    launch(32'hFFFF_FFF3, 32'd1000, 1'b0);
    cyc = 1;
    repeat (5) begin @(posedge clk); @(negedge clk); cyc++; end
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h9ABC_DEF0;
    is_unsigned  = 1'b1;
    start = 1'b1;
    @(posedge clk); @(negedge clk); cyc++;
    start = 1'b0;
    wait_done(cyc);
    check("busy_start_latency", cyc, 34);
    check("busy_start_hi", hi, exp[63:32]);
    check("busy_start_lo", lo, exp[31:0]);
    repeat (40) @(negedge clk);
    check("busy_start_pulses", done_count - pulses, 1);

    // reset in the middle of an operation
    launch(32'd1000, 32'd2000, 1'b0);
    repeat (19) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    start = 1'b1;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    run_op("after_rst_3x5", 32'd3, 32'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
